// File: rtl/mac_psum_acc_pkg.sv
// Shared widths for the MAC -> accumulator -> OFIFO path.
// The cfg_len decode is used wherever a 4-bit length field is interpreted.
package mac_psum_acc_pkg;

    localparam int bw      = 8;
    localparam int bw_psum = 2 * bw + 6;
    localparam int bw_acc  = bw_psum + 4;

    // A cfg_len of 0 selects the full 16-psum tile.
    localparam logic [4:0] len_full = 5'd16;

    function automatic logic [4:0] decode_len(input logic [3:0] len);
        return (len == 4'd0) ? len_full : {1'b0, len};
    endfunction

endpackage

// File: rtl/mac_psum_acc_quant.sv
// psum_quant: arithmetic shift, optional ReLU, saturation to bw bits.
// Latency: combinational. Backpressure: none (pure function).
// Shift amounts >= bw_acc leave only sign fill (0 or -1).
module psum_quant
    import mac_psum_acc_pkg::*;
(
    input  logic signed [bw_acc-1:0] sum,
    input  logic        [4:0]        shift,
    input  logic                     relu,
    output logic        [bw-1:0]     q,
    output logic                     sat
);

    localparam logic signed [bw_acc-1:0] umax = bw_acc'((1 << bw) - 1);
    localparam logic signed [bw_acc-1:0] smax = bw_acc'((1 << (bw - 1)) - 1);
    localparam logic signed [bw_acc-1:0] smin = bw_acc'(-(1 << (bw - 1)));

    logic signed [bw_acc-1:0] s;

    always_comb begin
        s   = sum >>> shift;
        q   = s[bw-1:0];
        sat = 1'b0;
        if (relu) begin
            if (s < 0) begin
                q = '0;
            end else if (s > umax) begin
                q   = '1;
                sat = 1'b1;
            end
        end else begin
            if (s > smax) begin
                q   = smax[bw-1:0];
                sat = 1'b1;
            end else if (s < smin) begin
                q   = smin[bw-1:0];
                sat = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_psum_acc.sv
// Accumulates cfg_len MAC partial sums into one result, emitted raw and requantized.
// Latency: result registered the cycle after the final psum; one psum/cycle throughput.
// Backpressure: in_ready drops while an unconsumed result is held; acc/cnt freeze.
module mac_psum_acc
    import mac_psum_acc_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic        [3:0]         cfg_len,
    input  logic        [4:0]         cfg_shift,
    input  logic                      cfg_relu,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [bw_psum-1:0] in_psum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [bw_acc-1:0]  out_acc,
    output logic        [bw-1:0]      out_q,
    output logic                      out_sat
);

    logic signed [bw_acc-1:0] acc;
    logic        [3:0]        cnt;
    logic        [4:0]        len_l;
    logic        [4:0]        shift_l;
    logic                     relu_l;

    logic                     xfer;
    logic                     first;
    logic                     final_xfer;
    logic        [4:0]        len_e;
    logic        [4:0]        shift_e;
    logic                     relu_e;
    logic signed [bw_acc-1:0] sum;
    logic        [bw-1:0]     q_nxt;
    logic                     sat_nxt;

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    assign first    = (cnt == 4'd0);

    // The first psum of a result uses live cfg; later psums use the copy taken then.
    assign len_e   = first ? decode_len(cfg_len) : len_l;
    assign shift_e = first ? cfg_shift : shift_l;
    assign relu_e  = first ? cfg_relu  : relu_l;

    assign final_xfer = xfer && ({1'b0, cnt} == len_e - 5'd1);
    assign sum = (first ? '0 : acc)
               + {{(bw_acc - bw_psum){in_psum[bw_psum-1]}}, in_psum};

    psum_quant u_quant (
        .sum   (sum),
        .shift (shift_e),
        .relu  (relu_e),
        .q     (q_nxt),
        .sat   (sat_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            cnt       <= '0;
            len_l     <= len_full;
            shift_l   <= '0;
            relu_l    <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_q     <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer) begin
                if (first) begin
                    len_l   <= len_e;
                    shift_l <= shift_e;
                    relu_l  <= relu_e;
                end
                if (final_xfer) begin
                    out_acc   <= sum;
                    out_q     <= q_nxt;
                    out_sat   <= sat_nxt;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: doc/mac_psum_acc.md
Name: mac_psum_acc

Overview:
Consumer end of the 16-input MAC output interface. Takes the 22-bit signed partial sums produced by the MAC, one per cycle. Accumulates a configurable number of them (K-tiles) into one wide result. Emits the result both raw and requantized (arithmetic shift, optional ReLU, saturation to bw bits) over a valid/ready handshake to the output SRAM/OFIFO path.

Parameters:
bw, 8, activation/output quantized width (matches MAC operand width)
bw_psum, 22, incoming MAC partial-sum width (2*bw+6), signed
bw_acc, 26, accumulator width (bw_psum+4); holds 16 worst-case psums without overflow

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
cfg_len  input  4  psums per result; 1..15 literal, 0 means 16
cfg_shift  input  5  arithmetic right shift applied before quantization
cfg_relu  input  1  1 = clamp negatives to 0 and saturate to unsigned [0,2^bw-1]; 0 = signed saturate
in_valid  input  1  in_psum valid
in_ready  output  1  block can accept in_psum this cycle
in_psum  input  bw_psum  signed MAC partial sum
out_valid  output  1  result registers hold an unconsumed result
out_ready  input  1  downstream accepts result
out_acc  output  bw_acc  signed raw accumulated sum
out_q  output  bw  requantized result (unsigned if relu latched, else two's complement)
out_sat  output  1  1 if out_q was clipped by saturation

Behaviour:
- Reset (async assert, sync release): acc=0, cnt=0, out_valid=0, out_acc=0, out_q=0, out_sat=0, latched cfg = {len 16, shift 0, relu 0}.
- Input handshake: transfer when in_valid && in_ready. in_ready = !out_valid || out_ready, combinational; output slot is free or freeing this cycle.
- cfg_len/cfg_shift/cfg_relu are sampled on the transfer with cnt==0 and held for that result. Changes mid-result are ignored.
- Each transfer: sum = (cnt==0 ? 0 : acc) + sext(in_psum to bw_acc).
  - If cnt == len_latched-1 (final): out_acc<=sum, out_q/out_sat<=quant(sum), out_valid<=1, cnt<=0, acc<=0.
  - Otherwise: acc<=sum, cnt<=cnt+1.
- Latency: result is visible the cycle after the final psum transfer. Throughput is one psum/cycle while out_ready=1. len=1 gives one result per cycle.
- Output handshake: out_valid drops the cycle after out_valid && out_ready, unless a final transfer happens in the same cycle. In that case out_valid stays 1 and new data loads (back-to-back).
- While out_valid && !out_ready: in_ready=0. acc and cnt are frozen. out_* are held stable.
- Implicit FSM on cnt (ACC) plus out_valid (FULL). in_valid without in_ready is never dropped or double-counted.
- quant(sum):
  - s = sum >>> shift (arithmetic). shift >= bw_acc yields 0 or -1.
  - relu=1: s<0 -> 0, sat=0; s>255 -> 255, sat=1.
  - relu=0: clip to [-128,127], sat=1 when clipped.
- No overflow of acc is possible for len<=16 and legal 22-bit psums; no overflow flag is provided.
- Reset mid-result discards the partial accumulation and any pending output.

Decomposition:
- Shared package: bw, bw_psum, bw_acc constants and the cfg_len 0->16 decode constant, shared with the MAC and OFIFO.
- One combinational sub-module, psum_quant (sum, shift, relu -> q, sat). It is reused by the later multi-core normalization path.
- Accumulator, counter and handshake logic stay in mac_psum_acc.

Test Plan:
- len=2, shift=0, relu=0, psums 100 then -30, out_ready=1 -> one result: out_acc=70, out_q=70, out_sat=0, out_valid high exactly one cycle.
- len=1, shift=2, psum 1000: relu=0 -> out_acc=1000, out_q=127, sat=1. Repeat with relu=1 -> out_q=250, sat=0. Psum -500 with relu=1 -> out_q=0, sat=0.
- cfg_len=0 (16), 16 psums of 262144 -> out_acc=4194304. 16 psums of -2097152 -> out_acc=-33554432, no wrap. Both with relu=0, shift=0 -> out_q saturates, sat=1.
- len=3, result ready, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_* stable, no psum lost. Release -> next result equals the exact sum of the next 3 psums.
- len=1, continuous in_valid with out_ready=1 -> back-to-back results every cycle, out_valid continuously high. Change cfg_len mid-result with len=4 -> the current result still uses 4.
- Assert reset_n=0 after 2 of 4 psums -> all outputs 0 immediately. After release, the next 4 psums produce only their own sum.
